// File: rtl/qspi_arb_pkg.sv
// Shared definitions for the QSPI arbiter slice.
//   state_t      : controller state encoding (IDLE -> WAIT -> RELEASE)
//   REQ_I/D/X    : requester index constants used to record the owner
//   tag_w()      : line tag width from physical address width and line length
package qspi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [1:0] REQ_I = 2'd0;
  localparam logic [1:0] REQ_D = 2'd1;
  localparam logic [1:0] REQ_X = 2'd2;

  function automatic int tag_w(input int pa, input int line_length);
    return pa - $clog2(line_length);
  endfunction

endpackage

// File: rtl/qspi_arb_age.sv
// Saturating age counter for one ageing requester.
//   clk, reset : clock, asynchronous active-low reset
//   inc        : requester lost an arbitration it took part in
//   clr        : requester won, or was not requesting at arbitration
//   sat        : counter has reached AGE_MAX; requester must win next time
module qspi_arb_age
  import qspi_arb_pkg::*;
#(
  parameter int AGE_MAX = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = $clog2(AGE_MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign sat = (cnt == CW'(AGE_MAX));

endmodule

// File: rtl/qspi_arb.sv
// Arbiter for the single QSPI line-transfer engine.
// Three requesters (icache refill i_*, dcache d_*, auxiliary x_*) compete;
// one transaction is run at a time. The winner's tag, memory select and
// direction are latched and held on q_* for the whole line transfer.
//   clk, reset     : clock, asynchronous active-low reset
//   *_req/_tag/... : requester inputs (level requests)
//   *_gnt          : requester owns the engine
//   *_done         : one-cycle completion pulse to the owner
//   q_req/q_*      : request and latched transfer fields to the engine
//   q_done         : engine finished the line
//   q_abort, err   : watchdog expiry; pulse together with the owner's *_done
module qspi_arb
  import qspi_arb_pkg::*;
#(
  parameter  int PA          = 24,
  parameter  int LINE_LENGTH = 4,
  parameter  int AGE_MAX     = 7,
  parameter  int TIMEOUT     = 255,
  localparam int TW          = tag_w(PA, LINE_LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [TW-1:0] i_tag,
  input  logic [1:0]    i_mem,
  output logic          i_gnt,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_write,
  input  logic [TW-1:0] d_tag,
  input  logic [1:0]    d_mem,
  output logic          d_gnt,
  output logic          d_done,
  input  logic          x_req,
  input  logic          x_write,
  input  logic [TW-1:0] x_tag,
  input  logic [1:0]    x_mem,
  output logic          x_gnt,
  output logic          x_done,
  output logic          q_req,
  output logic          q_i_d,
  output logic          q_write,
  output logic [TW-1:0] q_paddr,
  output logic [1:0]    q_mem,
  input  logic          q_done,
  output logic          q_abort,
  output logic          err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [1:0]      owner;
  logic [WD_W-1:0] wd;
  logic [1:0]      win;
  logic            any_req;
  logic            arb;
  logic            i_sat, x_sat;

  assign any_req = i_req | d_req | x_req;
  assign arb     = (state == ST_IDLE) && any_req;

  // A saturated counter only forces a win while that requester still asks;
  // otherwise plain priority d > i > x applies.
  always_comb begin
    win = REQ_X;
    if (i_req && i_sat)      win = REQ_I;
    else if (x_req && x_sat) win = REQ_X;
    else if (d_req)          win = REQ_D;
    else if (i_req)          win = REQ_I;
  end

  qspi_arb_age #(.AGE_MAX(AGE_MAX)) u_age_i (
    .clk   (clk),
    .reset (reset),
    .inc   (arb && i_req && (win != REQ_I)),
    .clr   (arb && (!i_req || (win == REQ_I))),
    .sat   (i_sat)
  );

  qspi_arb_age #(.AGE_MAX(AGE_MAX)) u_age_x (
    .clk   (clk),
    .reset (reset),
    .inc   (arb && x_req && (win != REQ_X)),
    .clr   (arb && (!x_req || (win == REQ_X))),
    .sat   (x_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      owner   <= REQ_I;
      wd      <= '0;
      i_gnt   <= 1'b0;
      d_gnt   <= 1'b0;
      x_gnt   <= 1'b0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      x_done  <= 1'b0;
      q_req   <= 1'b0;
      q_i_d   <= 1'b0;
      q_write <= 1'b0;
      q_paddr <= '0;
      q_mem   <= '0;
      q_abort <= 1'b0;
      err     <= 1'b0;
    end else begin
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      x_done  <= 1'b0;
      q_abort <= 1'b0;
      err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state <= ST_WAIT;
            owner <= win;
            wd    <= '0;
            q_req <= 1'b1;
            i_gnt <= (win == REQ_I);
            d_gnt <= (win == REQ_D);
            x_gnt <= (win == REQ_X);
            q_i_d <= (win == REQ_I);
            case (win)
              REQ_D: begin
                q_write <= d_write;
                q_paddr <= d_tag;
                q_mem   <= d_mem;
              end
              REQ_X: begin
                q_write <= x_write;
                q_paddr <= x_tag;
                q_mem   <= x_mem;
              end
              default: begin
                q_write <= 1'b0;
                q_paddr <= i_tag;
                q_mem   <= i_mem;
              end
            endcase
          end
        end
        ST_WAIT: begin
          // q_done on the expiry cycle wins over the watchdog: no abort, no err.
          if (q_done || (wd == WD_W'(TIMEOUT - 1))) begin
            state   <= ST_RELEASE;
            q_req   <= 1'b0;
            i_gnt   <= 1'b0;
            d_gnt   <= 1'b0;
            x_gnt   <= 1'b0;
            i_done  <= (owner == REQ_I);
            d_done  <= (owner == REQ_D);
            x_done  <= (owner == REQ_X);
            q_abort <= !q_done;
            err     <= !q_done;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
          wd    <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_arb.sv
// Directed bench for qspi_arb: single request, priority, ageing, watchdog
// expiry, q_done on the expiry cycle, and reset during a transfer.
module tb_qspi_arb;
  import qspi_arb_pkg::*;

  localparam int PA          = 24;
  localparam int LINE_LENGTH = 4;
  localparam int AGE_MAX     = 7;
  localparam int TIMEOUT     = 255;
  localparam int TW          = tag_w(PA, LINE_LENGTH);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, x_req = 1'b0;
  logic          d_write = 1'b0, x_write = 1'b0;
  logic [TW-1:0] i_tag = '0, d_tag = '0, x_tag = '0;
  logic [1:0]    i_mem = '0, d_mem = '0, x_mem = '0;
  logic          q_done = 1'b0;
  logic          i_gnt, d_gnt, x_gnt, i_done, d_done, x_done;
  logic          q_req, q_i_d, q_write, q_abort, err;
  logic [TW-1:0] q_paddr;
  logic [1:0]    q_mem;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  qspi_arb #(.PA(PA), .LINE_LENGTH(LINE_LENGTH), .AGE_MAX(AGE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_tag(i_tag), .i_mem(i_mem), .i_gnt(i_gnt), .i_done(i_done),
    .d_req(d_req), .d_write(d_write), .d_tag(d_tag), .d_mem(d_mem), .d_gnt(d_gnt), .d_done(d_done),
    .x_req(x_req), .x_write(x_write), .x_tag(x_tag), .x_mem(x_mem), .x_gnt(x_gnt), .x_done(x_done),
    .q_req(q_req), .q_i_d(q_i_d), .q_write(q_write), .q_paddr(q_paddr), .q_mem(q_mem),
    .q_done(q_done), .q_abort(q_abort), .err(err)
  );

  task automatic check_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_t(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_m(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic step_n(input int n);
    for (int s = 0; s < n; s++) @(negedge clk);
  endtask

  // q_done is high for exactly one rising edge; returns on the RELEASE cycle.
  task automatic pulse_done();
    q_done = 1'b1;
    @(negedge clk);
    q_done = 1'b0;
  endtask

  // Grants and completion pulses must each be one-hot at every cycle.
  always @(negedge clk) begin
    if (reset) begin
      check_b("gnt_onehot", $countones({i_gnt, d_gnt, x_gnt}) <= 1, 1'b1);
      check_b("done_onehot", $countones({i_done, d_done, x_done}) <= 1, 1'b1);
    end
  end

  initial begin
    // Reset state
    step_n(2);
    check_b("rst_q_req", q_req, 1'b0);
    check_b("rst_i_gnt", i_gnt, 1'b0);
    check_b("rst_d_gnt", d_gnt, 1'b0);
    check_b("rst_x_gnt", x_gnt, 1'b0);
    check_b("rst_err", err, 1'b0);
    check_b("rst_abort", q_abort, 1'b0);
    check_b("rst_q_i_d", q_i_d, 1'b0);
    check_b("rst_q_write", q_write, 1'b0);
    check_t("rst_paddr", q_paddr, '0);
    check_m("rst_mem", q_mem, 2'd0);
    reset = 1'b1;
    step();

    // Single icache request, q_done on WAIT cycle 10, then back-to-back regrant
    i_req = 1'b1; i_tag = TW'('h1234); i_mem = 2'd1;
    step();
    check_b("t1_q_req", q_req, 1'b1);
    check_b("t1_i_gnt", i_gnt, 1'b1);
    check_t("t1_paddr", q_paddr, TW'('h1234));
    check_m("t1_mem", q_mem, 2'd1);
    check_b("t1_q_i_d", q_i_d, 1'b1);
    check_b("t1_q_write", q_write, 1'b0);
    i_tag = TW'('h3FFF);
    step_n(9);
    check_b("t1_hold_gnt", i_gnt, 1'b1);
    check_t("t1_hold_paddr", q_paddr, TW'('h1234));
    pulse_done();
    check_b("t1_i_done", i_done, 1'b1);
    check_b("t1_gnt_drop", i_gnt, 1'b0);
    check_b("t1_q_req_low1", q_req, 1'b0);
    check_b("t1_err", err, 1'b0);
    check_b("t1_abort", q_abort, 1'b0);
    step();
    check_b("t1_q_req_low2", q_req, 1'b0);
    check_b("t1_done_once", i_done, 1'b0);
    step();
    check_b("t1_regrant", q_req, 1'b1);
    check_t("t1_regrant_paddr", q_paddr, TW'('h3FFF));
    i_req = 1'b0; i_tag = TW'('h1234);
    pulse_done();
    step();

    // All three at once: d, then i, then x
    d_req = 1'b1; d_write = 1'b1; d_tag = TW'('h0AAA); d_mem = 2'd2;
    x_req = 1'b1; x_write = 1'b1; x_tag = TW'('h0555); x_mem = 2'd3;
    i_req = 1'b1;
    step();
    check_b("t2_d_gnt", d_gnt, 1'b1);
    check_b("t2_d_write", q_write, 1'b1);
    check_t("t2_d_paddr", q_paddr, TW'('h0AAA));
    check_b("t2_d_q_i_d", q_i_d, 1'b0);
    d_req = 1'b0;
    pulse_done();
    check_b("t2_d_done", d_done, 1'b1);
    check_b("t2_d_i_done", i_done, 1'b0);
    step_n(2);
    check_b("t2_i_gnt", i_gnt, 1'b1);
    check_b("t2_i_write", q_write, 1'b0);
    check_b("t2_i_q_i_d", q_i_d, 1'b1);
    check_t("t2_i_paddr", q_paddr, TW'('h1234));
    i_req = 1'b0;
    pulse_done();
    check_b("t2_i_done", i_done, 1'b1);
    step_n(2);
    check_b("t2_x_gnt", x_gnt, 1'b1);
    check_b("t2_x_write", q_write, 1'b1);
    check_m("t2_x_mem", q_mem, 2'd3);
    check_t("t2_x_paddr", q_paddr, TW'('h0555));
    x_req = 1'b0;
    step();
    check_b("t2_x_drop_no_abort", x_gnt, 1'b1);
    pulse_done();
    check_b("t2_x_done", x_done, 1'b1);
    check_b("t2_x_no_err", err, 1'b0);
    step();

    // Starvation: x held while d and i alternate; x forced on arbitration 8
    x_req = 1'b1; x_write = 1'b0; x_tag = TW'('h0777);
    for (int k = 1; k <= 9; k++) begin
      d_req = (k % 2) == 1;
      i_req = (k % 2) == 0;
      step();
      check_b($sformatf("t3_x_gnt_%0d", k), x_gnt, k == 8);
      check_b($sformatf("t3_d_gnt_%0d", k), d_gnt, ((k % 2) == 1) && (k != 8));
      check_b($sformatf("t3_i_gnt_%0d", k), i_gnt, ((k % 2) == 0) && (k != 8));
      pulse_done();
      step();
    end
    x_req = 1'b0; d_req = 1'b0; i_req = 1'b0;
    step();
    check_b("t3_idle", q_req, 1'b0);

    // Watchdog expiry on a dcache transfer
    d_req = 1'b1; d_write = 1'b0; d_tag = TW'('h0BEE); d_mem = 2'd1;
    step();
    check_b("t4_d_gnt", d_gnt, 1'b1);
    d_req = 1'b0;
    step_n(TIMEOUT - 1);
    check_b("t4_still_wait", q_req, 1'b1);
    check_b("t4_no_abort_yet", q_abort, 1'b0);
    check_b("t4_no_done_yet", d_done, 1'b0);
    step();
    check_b("t4_abort", q_abort, 1'b1);
    check_b("t4_err", err, 1'b1);
    check_b("t4_d_done", d_done, 1'b1);
    check_b("t4_q_req", q_req, 1'b0);
    check_b("t4_gnt_drop", d_gnt, 1'b0);
    step();
    check_b("t4_abort_pulse", q_abort, 1'b0);
    check_b("t4_err_pulse", err, 1'b0);
    check_b("t4_done_pulse", d_done, 1'b0);
    step();
    check_b("t4_idle", q_req, 1'b0);

    // q_done on the expiry cycle is a normal completion
    d_req = 1'b1;
    step();
    d_req = 1'b0;
    check_b("t5_d_gnt", d_gnt, 1'b1);
    step_n(TIMEOUT - 1);
    pulse_done();
    check_b("t5_d_done", d_done, 1'b1);
    check_b("t5_err", err, 1'b0);
    check_b("t5_abort", q_abort, 1'b0);
    step();

    // Reset during WAIT, then clean regrant of the pending icache request
    i_req = 1'b1; i_tag = TW'('h00F0); i_mem = 2'd2;
    step();
    check_b("t6_i_gnt", i_gnt, 1'b1);
    step_n(3);
    #2 reset = 1'b0;
    #1;
    check_b("t6_async_q_req", q_req, 1'b0);
    check_b("t6_async_gnt", i_gnt, 1'b0);
    check_t("t6_async_paddr", q_paddr, '0);
    check_b("t6_async_q_i_d", q_i_d, 1'b0);
    check_m("t6_async_mem", q_mem, 2'd0);
    step();
    check_b("t6_held_q_req", q_req, 1'b0);
    reset = 1'b1;
    step();
    check_b("t6_regrant", i_gnt, 1'b1);
    check_b("t6_regrant_q_req", q_req, 1'b1);
    check_t("t6_regrant_paddr", q_paddr, TW'('h00F0));
    check_m("t6_regrant_mem", q_mem, 2'd2);
    i_req = 1'b0;
    pulse_done();
    check_b("t6_i_done", i_done, 1'b1);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
